// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle RV32I sequencer (FETCH/DECODE/EXEC/MEM/WB) for a shared
// datapath, trapping on illegal opcodes and on memory handshakes that exceed MEM_TIMEOUT cycles.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       branch_taken,
    output logic       imem_req,
    output logic       ir_write,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       reg_write,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic [1:0] alu_op,
    output logic [1:0] rw_sel,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       retire,
    output logic       trap,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        RST    = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT == 0 ? 0 : MEM_TIMEOUT - 1);

    state_t          state;
    logic [6:0]      op_q;
    logic [TO_W-1:0] wait_cnt;
    logic            ready;
    logic            timeout;
    logic            legal;

    // Only the ready of the memory currently being waited on matters.
    assign ready   = (state == FETCH) ? imem_ready : dmem_ready;
    assign legal   = opcode inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST) && !ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RST;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                RST:     state <= FETCH;
                FETCH:   state <= imem_ready ? DECODE : (timeout ? TRAP : FETCH);
                DECODE: begin
                    op_q  <= opcode;
                    state <= legal ? EXEC : TRAP;
                end
                EXEC:    state <= (op_q == OP_LW || op_q == OP_SW) ? MEM : ((op_q == OP_BR) ? FETCH : WB);
                MEM:     state <= dmem_ready ? ((op_q == OP_LW) ? WB : FETCH) : (timeout ? TRAP : MEM);
                WB:      state <= FETCH;
                default: state <= TRAP;
            endcase
            // Zero outside the waiting states, so every entry to FETCH/MEM starts from a clean count.
            wait_cnt <= ((state == FETCH || state == MEM) && !ready) ? ((&wait_cnt) ? wait_cnt : wait_cnt + 1'b1) : '0;
        end
    end

    always_comb begin
        imem_req   = state == FETCH;
        ir_write   = state == FETCH && imem_ready;
        dmem_req   = state == MEM;
        dmem_we    = state == MEM && op_q == OP_SW;
        reg_write  = state == WB;
        mem_to_reg = state == WB && op_q == OP_LW;
        trap       = state == TRAP;
        state_dbg  = state;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        rw_sel     = 2'b00;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        retire     = 1'b0;
        case (state)
            EXEC: begin
                alu_src  = op_q inside {OP_LW, OP_SW, OP_I, OP_JALR};
                alu_op   = (op_q == OP_BR) ? 2'b01 :
                           (op_q inside {OP_R, OP_I}) ? 2'b10 :
                           (op_q inside {OP_JAL, OP_LUI}) ? 2'b11 : 2'b00;
                pc_write = op_q == OP_BR;
                pc_src   = {1'b0, op_q == OP_BR && branch_taken};
                retire   = op_q == OP_BR;
            end
            MEM: begin
                alu_src  = 1'b1;
                pc_write = dmem_ready && op_q == OP_SW;
                retire   = dmem_ready && op_q == OP_SW;
            end
            WB: begin
                retire   = 1'b1;
                pc_write = 1'b1;
                alu_src  = op_q == OP_JALR;
                rw_sel   = (op_q inside {OP_JAL, OP_JALR}) ? 2'b01 :
                           (op_q == OP_LUI) ? 2'b10 :
                           (op_q == OP_AUIPC) ? 2'b11 : 2'b00;
                pc_src   = (op_q == OP_JAL) ? 2'b01 : ((op_q == OP_JALR) ? 2'b10 : 2'b00);
            end
            default: ;
        endcase
    end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle RV32I sequencer. Replaces the single-cycle decoder's static strobes with a state machine over FETCH / DECODE / EXECUTE / MEM / WRITEBACK.
- Drives PC, IR, register-file and memory enables for a shared datapath (one ALU, separate I/D memory ports with ready handshakes).
- Traps on illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles for imem_ready/dmem_ready before TRAP; 0 disables the timeout.
- TO_W, 5: width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  7  IR[6:0]; valid from DECODE onward
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- branch_taken  in  1  branch comparator result, valid in EXECUTE
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load IR from imem data
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- reg_write  out  1  register file write enable
- alu_src  out  1  1 = immediate operand B
- mem_to_reg  out  1  1 = writeback from dmem data
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded, 11 JAL/LUI
- rw_sel  out  2  00 ALU/mem, 01 PC+4, 10 imm, 11 PC+imm
- pc_write  out  1  PC update enable
- pc_src  out  2  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky error flag
- state_dbg  out  3  current state encoding

Behaviour:
- Opcode classes: R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Any other opcode is illegal.
- State encoding: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Outputs are combinational from state and op_q (registered opcode). Every output not listed for a state is 0.
- Reset (asynchronous): state=RST, op_q=0, wait_cnt=0, trap=0. In RST all outputs are 0 except state_dbg=0. RST→FETCH unconditionally.
- FETCH: imem_req=1. When imem_ready=1: ir_write=1 in the same cycle, go to DECODE.
- DECODE: op_q<=opcode. Illegal opcode → TRAP; otherwise → EXEC.
- EXEC: alu_src and alu_op match the single-cycle encoding:
  - alu_src=1 for LW, SW, I, JALR.
  - alu_op: 01 for BR; 10 for R and I; 11 for JAL and LUI; 00 otherwise.
  - Transitions: LW/SW → MEM. BR: pc_write=1, pc_src = branch_taken ? 01 : 00, retire=1, → FETCH. All other classes → WB.
- MEM: dmem_req=1, dmem_we=(op_q==SW), alu_src=1, alu_op=00. On dmem_ready: LW → WB; SW → pc_write=1, pc_src=00, retire=1, → FETCH.
- WB: reg_write=1, retire=1, pc_write=1.
  - mem_to_reg=(op_q==LW).
  - rw_sel: 01 JAL/JALR; 10 LUI; 11 AUIPC; 00 otherwise.
  - pc_src: 01 JAL; 10 JALR; 00 otherwise.
  - For JALR, alu_src=1 and alu_op=00 are held so the target stays valid.
  - → FETCH.
- TRAP: trap=1, all strobes 0. Exits only via reset.
- Wait counter:
  - Clears on entry to FETCH/MEM and on every ready.
  - Increments each FETCH/MEM cycle with ready=0, saturating at 2^TO_W-1.
  - If MEM_TIMEOUT≠0 and wait_cnt==MEM_TIMEOUT-1 with ready still 0 → TRAP next cycle. Total allowed wait = MEM_TIMEOUT cycles.
  - A ready arriving in the timeout cycle wins (normal transition).
- Latency with zero-wait memories:
  - 3 cycles: BR.
  - 4 cycles: R, I, LUI, AUIPC, JAL, JALR, SW.
  - 5 cycles: LW.
  - The first FETCH follows 1 cycle of RST.
- branch_taken and the ready inputs are ignored outside their states.
- opcode is sampled only in DECODE; changes elsewhere have no effect.
- Reset asserted mid-instruction: immediate return to RST and all strobes drop asynchronously. No partial reg_write or dmem_we may follow.

Test Plan:
- Reset, then zero-wait memories and opcode 0110011 → states 0,1,2,3,5,1; reg_write=1 and retire=1 only in WB; alu_op=10.
- LW with dmem_ready delayed 3 cycles → MEM held 4 cycles with dmem_req=1 and dmem_we=0; WB has mem_to_reg=1, rw_sel=00.
- BR with branch_taken=1, then with branch_taken=0 → EXEC pc_write=1 with pc_src=01 and 00 respectively; no reg_write; 3-cycle instruction.
- JALR → EXEC alu_src=1 alu_op=00; WB rw_sel=01, pc_src=10, reg_write=1. JAL → alu_op=11, pc_src=01.
- Opcode 1111111 → TRAP at cycle after DECODE; trap stays 1 across 20 cycles; reset clears it to state 0.
- MEM_TIMEOUT=4 with imem_ready held 0 → TRAP after exactly 4 FETCH cycles. Separate run with imem_ready in the 4th cycle → DECODE. Separate run asserting reset mid-MEM of a SW → dmem_we drops immediately.
